// File: rtl/editor_pkg.sv
// Shared types and constants for the text editor controller.
// Holds FSM states, control codes and the printable range.
package editor_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CLEAR
  } state_t;

  localparam logic [6:0] C_BS    = 7'h08;
  localparam logic [6:0] C_FF    = 7'h0C;
  localparam logic [6:0] C_CR    = 7'h0D;
  localparam logic [6:0] C_UP    = 7'h11;
  localparam logic [6:0] C_DN    = 7'h12;
  localparam logic [6:0] C_LF    = 7'h13;
  localparam logic [6:0] C_RT    = 7'h14;
  localparam logic [6:0] C_SPACE = 7'h20;
  localparam logic [6:0] C_PR_LO = 7'h20;
  localparam logic [6:0] C_PR_HI = 7'h7E;

  function automatic logic is_print(logic [6:0] c);
    return (c >= C_PR_LO) && (c <= C_PR_HI);
  endfunction

endpackage

// File: rtl/cursor_blink.sv
// Cursor blink timer: half-period down-counter and phase flop.
// restart forces a solid cursor; hold parks the timer reloaded.
module cursor_blink
  import editor_pkg::*;
#(
  parameter int BLINK_CYCLES = 3145728
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  input  logic i_hold,
  output logic o_on
);

  localparam int CW = $clog2(BLINK_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(BLINK_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_on;

  // Count down each cycle, toggling the phase when the count expires
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= RELOAD;
      r_on  <= 1'b1;
    end else if (i_restart) begin
      r_cnt <= RELOAD;
      r_on  <= 1'b1;
    end else if (i_hold) begin
      r_cnt <= RELOAD;
    end else if (r_cnt == '0) begin
      r_cnt <= RELOAD;
      r_on  <= ~r_on;
    end else begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_on = r_on;

endmodule

// File: rtl/text_editor_ctrl.sv
// Keyboard-driven text editor: cursor control, cell writes
// and full-screen clear into a character RAM.
module text_editor_ctrl
  import editor_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int COLOR_W      = 6,
  parameter int BLINK_CYCLES = 3145728,
  localparam int X_W         = $clog2(COLS),
  localparam int Y_W         = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [6:0]         key_ascii,
  output logic               key_ready,
  input  logic [COLOR_W-1:0] cfg_color,
  output logic               wr_en,
  output logic [X_W-1:0]     wr_x,
  output logic [Y_W-1:0]     wr_y,
  output logic [6:0]         wr_ascii,
  output logic [COLOR_W-1:0] wr_color,
  output logic [X_W-1:0]     cur_x,
  output logic [Y_W-1:0]     cur_y,
  output logic               cur_on,
  output logic               busy
);

  localparam logic [X_W-1:0] XMAX = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(ROWS - 1);
  localparam logic [X_W-1:0] XONE = X_W'(1);
  localparam logic [Y_W-1:0] YONE = Y_W'(1);

  state_t             r_state;
  logic [6:0]         r_code;
  logic [COLOR_W-1:0] r_color;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic               r_wen;
  logic [X_W-1:0]     r_wx;
  logic [Y_W-1:0]     r_wy;
  logic [6:0]         r_wa;
  logic [COLOR_W-1:0] r_wc;
  logic               r_busy;
  logic               r_ready;

  logic               w_acc;
  logic [6:0]         w_code;
  logic [X_W-1:0]     w_nx;
  logic [Y_W-1:0]     w_ny;
  logic               w_we;
  logic [X_W-1:0]     w_wx;
  logic [Y_W-1:0]     w_wy;
  logic [6:0]         w_wa;
  logic               w_on;

  assign w_acc  = key_valid & r_ready;
  // Fresh key at acceptance, latched key when applying the move
  assign w_code = (r_state == S_APPLY) ? r_code : key_ascii;

  // Decode a code into the next cursor and the cell write it implies
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    w_we = 1'b0;
    w_wa = C_SPACE;
    unique case (1'b1)
      is_print(w_code): begin
        w_we = 1'b1;
        w_wa = w_code;
        if (r_x == XMAX) begin
          w_nx = '0;
          w_ny = (r_y == YMAX) ? '0 : r_y + YONE;
        end else begin
          w_nx = r_x + XONE;
        end
      end
      (w_code == C_BS): begin
        w_we = 1'b1;
        if (r_x != '0) begin
          w_nx = r_x - XONE;
        end else if (r_y != '0) begin
          w_nx = XMAX;
          w_ny = r_y - YONE;
        end
      end
      (w_code == C_CR): begin
        w_nx = '0;
        w_ny = (r_y == YMAX) ? '0 : r_y + YONE;
      end
      (w_code == C_UP): if (r_y != '0) w_ny = r_y - YONE;
      (w_code == C_DN): if (r_y != YMAX) w_ny = r_y + YONE;
      (w_code == C_LF): if (r_x != '0) w_nx = r_x - XONE;
      (w_code == C_RT): if (r_x != XMAX) w_nx = r_x + XONE;
      default: ;
    endcase
  end

  // Backspace writes at the new cell, printables at the old one
  assign w_wx = (w_code == C_BS) ? w_nx : r_x;
  assign w_wy = (w_code == C_BS) ? w_ny : r_y;

  // Control FSM with registered write port, handshake and busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_color <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_wen   <= 1'b0;
      r_wx    <= '0;
      r_wy    <= '0;
      r_wa    <= '0;
      r_wc    <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          r_wen   <= 1'b0;
          if (w_acc) begin
            r_state <= S_APPLY;
            r_code  <= key_ascii;
            r_color <= cfg_color;
            r_ready <= 1'b0;
            r_wen   <= w_we;
            r_wx    <= w_wx;
            r_wy    <= w_wy;
            r_wa    <= w_wa;
            r_wc    <= cfg_color;
          end
        end
        S_APPLY: begin
          if (r_code == C_FF) begin
            r_state <= S_CLEAR;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b1;
            r_wen   <= 1'b1;
            r_wx    <= '0;
            r_wy    <= '0;
            r_wa    <= C_SPACE;
            r_wc    <= r_color;
          end else begin
            r_state <= S_IDLE;
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_wen   <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_wx == XMAX && r_wy == YMAX) begin
            r_state <= S_IDLE;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else if (r_wx == XMAX) begin
            r_wx <= '0;
            r_wy <= r_wy + YONE;
          end else begin
            r_wx <= r_wx + XONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wen   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  cursor_blink #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_restart(w_acc),
    .i_hold   (r_busy),
    .o_on     (w_on)
  );

  assign key_ready = r_ready;
  assign wr_en     = r_wen;
  assign wr_x      = r_wx;
  assign wr_y      = r_wy;
  assign wr_ascii  = r_wa;
  assign wr_color  = r_wc;
  assign cur_x     = r_x;
  assign cur_y     = r_y;
  assign cur_on    = w_on & ~r_busy;
  assign busy      = r_busy;

endmodule

// File: tb/tb_text_editor_ctrl.sv
// Bench for text_editor_ctrl: write scoreboard, cursor model,
// clear/abort sequences and blink timing on a small screen.
module tb_text_editor_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int CW   = 6;
  localparam int BL   = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [6:0] key_ascii = '0;
  logic       key_ready;
  logic [5:0] cfg_color = '0;
  logic       wr_en;
  logic [6:0] wr_x;
  logic [5:0] wr_y;
  logic [6:0] wr_ascii;
  logic [5:0] wr_color;
  logic [6:0] cur_x;
  logic [5:0] cur_y;
  logic       cur_on;
  logic       busy;

  logic       s_valid = 1'b0;
  logic [6:0] s_ascii = '0;
  logic       s_ready;
  logic       s_wr_en;
  logic [1:0] s_wr_x;
  logic [1:0] s_wr_y;
  logic [6:0] s_wr_ascii;
  logic [5:0] s_wr_color;
  logic [1:0] s_cur_x;
  logic [1:0] s_cur_y;
  logic       s_cur_on;
  logic       s_busy;

  always #5 clk = ~clk;

  text_editor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .COLOR_W(CW), .BLINK_CYCLES(BL)
  ) u_dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_ascii(key_ascii),
    .key_ready(key_ready), .cfg_color(cfg_color),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_ascii(wr_ascii), .wr_color(wr_color),
    .cur_x(cur_x), .cur_y(cur_y), .cur_on(cur_on),
    .busy(busy)
  );

  text_editor_ctrl #(
    .COLS(4), .ROWS(3), .COLOR_W(CW), .BLINK_CYCLES(5)
  ) u_small (
    .clk(clk), .reset(reset),
    .key_valid(s_valid), .key_ascii(s_ascii),
    .key_ready(s_ready), .cfg_color(cfg_color),
    .wr_en(s_wr_en), .wr_x(s_wr_x), .wr_y(s_wr_y),
    .wr_ascii(s_wr_ascii), .wr_color(s_wr_color),
    .cur_x(s_cur_x), .cur_y(s_cur_y), .cur_on(s_cur_on),
    .busy(s_busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q[$];
  logic [31:0] exp_w;
  int wr_seen = 0;
  int mx = 0;
  int my = 0;
  int clear_limit = COLS * ROWS;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_wr(int x, int y, logic [6:0] a, logic [5:0] c);
    q.push_back({6'b0, x[6:0], y[5:0], a, c});
  endtask

  task automatic model(logic [6:0] c, logic [5:0] col);
    case (c)
      7'h08: begin
        if (!(mx == 0 && my == 0)) begin
          if (mx == 0) begin
            mx = COLS - 1;
            my--;
          end else mx--;
        end
        push_wr(mx, my, 7'h20, col);
      end
      7'h0D: begin
        mx = 0;
        my = (my == ROWS - 1) ? 0 : my + 1;
      end
      7'h0C: begin
        mx = 0;
        my = 0;
        for (int k = 0; k < clear_limit; k++)
          push_wr(k % COLS, k / COLS, 7'h20, col);
      end
      7'h11: if (my > 0) my--;
      7'h12: if (my < ROWS - 1) my++;
      7'h13: if (mx > 0) mx--;
      7'h14: if (mx < COLS - 1) mx++;
      default: begin
        if (c >= 7'h20 && c <= 7'h7E) begin
          push_wr(mx, my, c, col);
          if (mx == COLS - 1) begin
            mx = 0;
            my = (my == ROWS - 1) ? 0 : my + 1;
          end else mx++;
        end
      end
    endcase
  endtask

  // Every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      wr_seen++;
      if (q.size() == 0) check("wr_extra", 32'(wr_en), 32'd0);
      else begin
        exp_w = q.pop_front();
        check("wr", {6'b0, wr_x, wr_y, wr_ascii, wr_color}, exp_w);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 10000; i++) begin
      if (key_ready) return;
      @(negedge clk);
    end
    check("ready_timeout", 32'(key_ready), 32'd1);
  endtask

  task automatic send(logic [6:0] c);
    wait_ready();
    model(c, cfg_color);
    key_ascii = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic chk_cur(string tag, int x, int y);
    @(negedge clk);
    check({tag, "_x"}, 32'(cur_x), 32'(x));
    check({tag, "_y"}, 32'(cur_y), 32'(y));
    check({tag, "_mx"}, 32'(cur_x), 32'(mx));
    check({tag, "_my"}, 32'(cur_y), 32'(my));
  endtask

  int tg[$];
  logic prev_on;
  int nb, nr, nw, no, target;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(key_ready), 32'd0);
    check("rst_wen", 32'(wr_en), 32'd0);
    check("rst_cur", {cur_x, cur_y}, 32'd0);
    check("rst_wr", {wr_x, wr_y, wr_ascii, wr_color}, 32'd0);
    check("rst_on", 32'(cur_on), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_on", 32'(s_cur_on), 32'd1);
    reset = 1'b0;
    prev_on = s_cur_on;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) check("ready_rise", 32'(key_ready), 32'd1);
      if (s_cur_on != prev_on) tg.push_back(i);
      prev_on = s_cur_on;
    end
    check("blink_n", tg.size(), 32'd3);
    if (tg.size() == 3) begin
      check("blink_t0", tg[0], 32'd5);
      check("blink_t1", tg[1] - tg[0], 32'd5);
      check("blink_t2", tg[2] - tg[1], 32'd5);
    end
    check("s_on_low", 32'(s_cur_on), 32'd0);
    s_ascii = 7'h13;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("s_on_forced", 32'(s_cur_on), 32'd1);
    @(negedge clk);
    check("s_left_cur", {s_cur_x, s_cur_y}, 32'd0);
    check("s_left_on", 32'(s_cur_on), 32'd1);
    check("s_no_wr", 32'(s_wr_en), 32'd0);

    cfg_color = 6'h2A;
    send(7'h41);
    check("lat1_wen", 32'(wr_en), 32'd1);
    check("apply_on", 32'(cur_on), 32'd1);
    chk_cur("after_A", 1, 0);
    check("after_A_on", 32'(cur_on), 32'd1);

    cfg_color = 6'h07;
    send(7'h0C);
    nb = 0; nr = 0; nw = 0; no = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (key_ready) nr++;
      if (wr_en) nw++;
      if (cur_on) no++;
    end
    check("clr_busy_len", nb, 32'd4800);
    check("clr_wr_cnt", nw, 32'd4800);
    check("clr_ready", nr, 32'd0);
    check("clr_cur_on", no, 32'd0);
    check("clr_cur", {cur_x, cur_y}, 32'd0);

    for (int i = 0; i < 59; i++) send(7'h12);
    for (int i = 0; i < 79; i++) send(7'h14);
    chk_cur("corner", 79, 59);
    send(7'h14);
    send(7'h12);
    chk_cur("sat", 79, 59);
    cfg_color = 6'h15;
    send(7'h42);
    chk_cur("wrap", 0, 0);
    send(7'h08);
    chk_cur("bs_origin", 0, 0);
    for (int i = 0; i < 5; i++) send(7'h12);
    send(7'h08);
    chk_cur("bs_row", 79, 4);
    send(7'h0D);
    chk_cur("cr", 0, 5);
    send(7'h01);
    chk_cur("other", 0, 5);
    send(7'h13);
    chk_cur("left_sat", 0, 5);
    send(7'h11);
    chk_cur("up", 0, 4);

    clear_limit = 100;
    target = wr_seen + 100;
    send(7'h0C);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (wr_seen >= target) break;
    end
    check("abort_reached", wr_seen, target);
    reset = 1'b1;
    mx = 0;
    my = 0;
    #1;
    check("abort_wen", 32'(wr_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cur", {cur_x, cur_y}, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    check("q_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
